// File: rtl/ysyx_22050710_sram_pkg.sv
// rtl/ysyx_22050710_sram_pkg.sv - shared encodings, response entry type and helpers for the SRAM slave
package ysyx_22050710_sram_pkg;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam logic [1:0] SIZE_1B = 2'd0;
   localparam logic [1:0] SIZE_2B = 2'd1;
   localparam logic [1:0] SIZE_4B = 2'd2;
   localparam logic [1:0] SIZE_8B = 2'd3;

   localparam int WORD_WD = 64;
   // Holds LATENCY (<=15) plus up to 3 random extra cycles.
   localparam int CNT_WD  = 5;

   localparam logic [3:0] LFSR_SEED = 4'hA;

   typedef struct packed {
      logic               op;
      logic [WORD_WD-1:0] rdata;
      logic [CNT_WD-1:0]  countdown;
   } resp_entry_t;

   function automatic logic [CNT_WD-1:0] cnt_dec(input logic [CNT_WD-1:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

endpackage

// File: rtl/ysyx_22050710_resp_queue.sv
// rtl/ysyx_22050710_resp_queue.sv - two-entry in-order response queue with per-entry countdowns
// An entry whose countdown is at most 1 is delivered at the next edge; a lone incoming entry may bypass storage.
module ysyx_22050710_resp_queue
   import ysyx_22050710_sram_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_push,
   input  resp_entry_t        i_entry,
   output logic               o_full,
   output logic               o_data_ok,
   output logic [WORD_WD-1:0] o_rdata
);

   logic [1:0]         valid_q, valid_d;
   resp_entry_t        entry_q [2];
   resp_entry_t        entry_d [2];
   resp_entry_t        push_entry, out_entry;
   logic               head_pop, bypass, deliver;
   logic               data_ok_q;
   logic [WORD_WD-1:0] rdata_q, rdata_d;

   assign head_pop  = valid_q[0] && (entry_q[0].countdown <= CNT_WD'(1));
   assign bypass    = i_push && !valid_q[0] && (i_entry.countdown <= CNT_WD'(1));
   assign deliver   = head_pop || bypass;
   assign out_entry = head_pop ? entry_q[0] : i_entry;
   assign rdata_d   = (deliver && out_entry.op == OP_READ) ? out_entry.rdata : '0;

   always_comb begin
      push_entry           = i_entry;
      push_entry.countdown = cnt_dec(i_entry.countdown);
      valid_d              = valid_q;
      for (int i = 0; i < 2; i++) begin
         entry_d[i]           = entry_q[i];
         entry_d[i].countdown = cnt_dec(entry_q[i].countdown);
      end
      if (head_pop) begin
         valid_d    = {1'b0, valid_q[1]};
         entry_d[0] = entry_d[1];
      end
      if (i_push && !bypass) begin
         if (!valid_d[0]) begin
            valid_d[0] = 1'b1;
            entry_d[0] = push_entry;
         end else begin
            valid_d[1] = 1'b1;
            entry_d[1] = push_entry;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q    <= '0;
         entry_q[0] <= '0;
         entry_q[1] <= '0;
         data_ok_q  <= 1'b0;
         rdata_q    <= '0;
      end else begin
         valid_q    <= valid_d;
         entry_q[0] <= entry_d[0];
         entry_q[1] <= entry_d[1];
         data_ok_q  <= deliver;
         rdata_q    <= rdata_d;
      end
   end

   assign o_full    = valid_q[1];
   assign o_data_ok = data_ok_q;
   assign o_rdata   = rdata_q;

endmodule

// File: rtl/ysyx_22050710_sram_slave.sv
// rtl/ysyx_22050710_sram_slave.sv - SRAM-like slave: byte-strobe word memory, accept logic, in-order responses
// Defining YSYX_22050710_SRAM_RAND_DELAY_EN adds 0..3 LFSR-chosen cycles to each response.
module ysyx_22050710_sram_slave
   import ysyx_22050710_sram_pkg::*;
#(
   parameter int                      SRAM_ADDR_WD  = 32,
   parameter int                      SRAM_DATA_WD  = 64,
   parameter int                      SRAM_WMASK_WD = 8,
   parameter int                      MEM_DEPTH     = 1024,
   parameter logic [SRAM_ADDR_WD-1:0] MEM_BASE      = 32'h8000_0000,
   parameter int                      LATENCY       = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_req,
   input  logic                     i_op,
   input  logic [1:0]               i_size,
   input  logic [SRAM_ADDR_WD-1:0]  i_addr,
   input  logic [SRAM_WMASK_WD-1:0] i_wstrb,
   input  logic [SRAM_DATA_WD-1:0]  i_wdata,
   output logic                     o_addr_ok,
   output logic                     o_data_ok,
   output logic [SRAM_DATA_WD-1:0]  o_rdata
);

   localparam int IDX_WD = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [WORD_WD-1:0]      mem_q [MEM_DEPTH];
   logic [SRAM_ADDR_WD-1:0] offset, word_idx;
   logic [IDX_WD-1:0]       idx;
   logic                    in_range, accept, queue_full;
   logic [WORD_WD-1:0]      rd_word, resp_rdata;
   logic [CNT_WD-1:0]       load;
   resp_entry_t             push_entry;
   logic                    unused_size;

   // Below-base addresses wrap to a huge index and fall out of range.
   assign offset    = i_addr - MEM_BASE;
   assign word_idx  = offset >> 3;
   assign in_range  = word_idx < SRAM_ADDR_WD'(MEM_DEPTH);
   assign idx       = word_idx[IDX_WD-1:0];
   assign o_addr_ok = !queue_full;
   assign accept    = i_req && o_addr_ok;
   assign rd_word   = (i_op == OP_READ && in_range) ? mem_q[idx] : '0;
   assign unused_size = ^i_size;

   always_ff @(posedge i_clk) begin
      if (accept && i_op == OP_WRITE && in_range) begin
         for (int b = 0; b < SRAM_WMASK_WD; b++) begin
            if (i_wstrb[b]) mem_q[idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

`ifdef YSYX_22050710_SRAM_RAND_DELAY_EN
   logic [3:0] lfsr_q, lfsr_d;

   assign lfsr_d = accept ? {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]} : lfsr_q;
   assign load   = CNT_WD'(LATENCY) + CNT_WD'(lfsr_q[1:0]);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign load = CNT_WD'(LATENCY);
`endif

   always_comb begin
      push_entry           = '0;
      push_entry.op        = i_op;
      push_entry.rdata     = rd_word;
      push_entry.countdown = load;
   end

   ysyx_22050710_resp_queue u_resp_queue (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_push    (accept),
      .i_entry   (push_entry),
      .o_full    (queue_full),
      .o_data_ok (o_data_ok),
      .o_rdata   (resp_rdata)
   );

   assign o_rdata = resp_rdata;

endmodule

// File: tb/tb_ysyx_22050710_sram_slave.sv
// tb/tb_ysyx_22050710_sram_slave.sv - self-checking bench for ysyx_22050710_sram_slave at LATENCY 1 and 3
module tb_ysyx_22050710_sram_slave;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst, req, op;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [7:0]  wstrb;
   logic [63:0] wdata;
   logic [1:0]  aok, dok;
   logic [63:0] rd [2];

   always #5 clk = ~clk;

   ysyx_22050710_sram_slave #(.LATENCY(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_size(size), .i_addr(addr),
      .i_wstrb(wstrb), .i_wdata(wdata), .o_addr_ok(aok[0]), .o_data_ok(dok[0]), .o_rdata(rd[0]));

   ysyx_22050710_sram_slave #(.LATENCY(3)) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_size(size), .i_addr(addr),
      .i_wstrb(wstrb), .i_wdata(wdata), .o_addr_ok(aok[1]), .o_data_ok(dok[1]), .o_rdata(rd[1]));

   typedef struct {
      int          d;
      int          acc;
      int          due;
      logic        op;
      logic [63:0] data;
      bit          chk;
   } resp_t;

   typedef struct {
      logic        op;
      logic [31:0] addr;
      logic [7:0]  strb;
      logic [63:0] data;
      logic [63:0] exp;
      string       nm;
   } vec_t;

   resp_t       pend[$];
   logic [63:0] mem_m [2][DEPTH];
   bit          known [2][DEPTH];
   logic [3:0]  lfsr_m [2];
   int          last_due [2];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          seen [2];
   logic [63:0] seen_data [2];
   int          seen_lat [2];
   int          pulses [2];
   logic        last_aok [2];
   logic        last_dok [2];
   logic [63:0] last_rd [2];
   int          ok_hist3[$];

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      for (int k = 0; k < 2; k++) begin
         last_due[k] = cyc;
         lfsr_m[k]   = 4'hA;
      end
   endtask

   // One clock: compare outputs at the falling edge, then advance the model across the rising edge.
   task automatic tick();
      logic        ea [2];
      int          occ, hi, widx;
      bit          inr;
      logic [31:0] off;
      int          extra;
      resp_t       e;
      resp_t       newq[$];
      resp_t       keep[$];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         occ = 0;
         hi  = -1;
         foreach (pend[j]) begin
            if (pend[j].d == k) begin
               if (pend[j].due > cyc) occ++;
               else if (pend[j].due == cyc && hi < 0) hi = j;
            end
         end
         ea[k] = (occ < 2);
         chk($sformatf("addr_ok_dut%0d", k), 64'(aok[k]), 64'(ea[k]));
         chk($sformatf("data_ok_dut%0d", k), 64'(dok[k]), 64'(hi >= 0));
         if (hi < 0) chk($sformatf("rdata_idle_dut%0d", k), rd[k], 64'd0);
         else if (pend[hi].chk)
            chk($sformatf("rdata_dut%0d", k), rd[k], (pend[hi].op == 1'b1) ? 64'd0 : pend[hi].data);
         if (dok[k]) begin
            pulses[k]++;
            seen[k]      = 1'b1;
            seen_data[k] = rd[k];
            seen_lat[k]  = (hi >= 0) ? cyc - pend[hi].acc : -1;
            if (k == 1) ok_hist3.push_back(cyc);
         end
         last_aok[k] = aok[k];
         last_dok[k] = dok[k];
         last_rd[k]  = rd[k];
      end
      for (int k = 0; k < 2; k++) begin
         if (req && ea[k] && !rst) begin
            off   = addr - BASE;
            widx  = int'(off >> 3);
            inr   = (off >> 3) < DEPTH;
            e.d   = k;
            e.acc = cyc;
            e.op  = op;
            if (op == 1'b0) begin
               e.data = inr ? mem_m[k][widx] : 64'd0;
               e.chk  = !inr || known[k][widx];
            end else begin
               e.data = 64'd0;
               e.chk  = 1'b1;
               if (inr) begin
                  for (int b = 0; b < 8; b++)
                     if (wstrb[b]) mem_m[k][widx][8*b +: 8] = wdata[8*b +: 8];
                  if (wstrb == 8'hFF) known[k][widx] = 1'b1;
               end
            end
            extra = 0;
`ifdef YSYX_22050710_SRAM_RAND_DELAY_EN
            extra     = int'(lfsr_m[k][1:0]);
            lfsr_m[k] = {lfsr_m[k][2:0], lfsr_m[k][3] ^ lfsr_m[k][2]};
`endif
            e.due = cyc + lat_of(k) + extra;
            if (e.due <= last_due[k]) e.due = last_due[k] + 1;
            last_due[k] = e.due;
            newq.push_back(e);
         end
      end
      @(posedge clk);
      foreach (pend[j]) if (pend[j].due != cyc) keep.push_back(pend[j]);
      pend = keep;
      foreach (newq[j]) pend.push_back(newq[j]);
      #1;
      cyc++;
   endtask

   task automatic xfer(input logic o, input logic [31:0] a, input logic [7:0] s,
                       input logic [63:0] d, input logic [63:0] exp, input string nm);
      int n;
      req = 1'b1; op = o; addr = a; wstrb = s; wdata = d; size = 2'($urandom);
      seen[0] = 1'b0; seen[1] = 1'b0;
      tick();
      req = 1'b0;
      n = 0;
      while (!(seen[0] && seen[1]) && n < 40) begin
         tick();
         n++;
      end
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_done_dut%0d", nm, k), 64'(seen[k]), 64'd1);
         chk($sformatf("%s_data_dut%0d", nm, k), seen_data[k], exp);
`ifndef YSYX_22050710_SRAM_RAND_DELAY_EN
         chk($sformatf("%s_lat_dut%0d", nm, k), 64'(seen_lat[k]), 64'(lat_of(k)));
`endif
      end
   endtask

   vec_t vt [14];
   int   t0;

   initial begin
      vt[0]  = '{1'b1, BASE,           8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0,                   "w_word0"};
      vt[1]  = '{1'b1, BASE + 32'd8,   8'hFF, 64'h1122_3344_5566_7788, 64'h0,                   "w_word1_full"};
      vt[2]  = '{1'b0, BASE + 32'd8,   8'h00, 64'h0,                   64'h1122_3344_5566_7788, "r_word1_full"};
      vt[3]  = '{1'b1, BASE + 32'd8,   8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0,                   "w_word1_low"};
      vt[4]  = '{1'b0, BASE + 32'd8,   8'h00, 64'h0,                   64'h1122_3344_BBBB_BBBB, "r_word1_merge"};
      vt[5]  = '{1'b0, BASE + 32'd13,  8'h00, 64'h0,                   64'h1122_3344_BBBB_BBBB, "r_word1_unaligned"};
      vt[6]  = '{1'b0, 32'h7FFF_FFF8,  8'h00, 64'h0,                   64'h0,                   "r_below_base"};
      vt[7]  = '{1'b1, 32'h8000_2000,  8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   "w_past_end"};
      vt[8]  = '{1'b0, BASE,           8'h00, 64'h0,                   64'h0123_4567_89AB_CDEF, "r_word0_unchanged"};
      vt[9]  = '{1'b1, BASE,           8'h80, 64'hEE00_0000_0000_0000, 64'h0,                   "w_word0_byte7"};
      vt[10] = '{1'b0, BASE,           8'h00, 64'h0,                   64'hEE23_4567_89AB_CDEF, "r_word0_byte7"};
      vt[11] = '{1'b1, 32'h8000_1FF8,  8'hFF, 64'h5A5A_0F0F_C3C3_9696, 64'h0,                   "w_last_word"};
      vt[12] = '{1'b0, 32'h8000_1FF8,  8'h00, 64'h0,                   64'h5A5A_0F0F_C3C3_9696, "r_last_word"};
      vt[13] = '{1'b0, 32'h8000_2000,  8'h00, 64'h0,                   64'h0,                   "r_past_end"};

      rst = 1'b1; req = 1'b0; op = 1'b0; size = 2'd0; addr = 32'd0; wstrb = 8'd0; wdata = 64'd0;
      pulses[0] = 0; pulses[1] = 0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset_addr_ok_dut%0d", k), 64'(last_aok[k]), 64'd1);
         chk($sformatf("reset_data_ok_dut%0d", k), 64'(last_dok[k]), 64'd0);
         chk($sformatf("reset_rdata_dut%0d", k), last_rd[k], 64'd0);
      end

      for (int i = 0; i < 14; i++)
         xfer(vt[i].op, vt[i].addr, vt[i].strb, vt[i].data, vt[i].exp, vt[i].nm);

      // Back-to-back requests: LATENCY=3 fills after two accepts, LATENCY=1 keeps accepting.
      ok_hist3.delete();
      t0 = cyc;
      req = 1'b1; op = 1'b0; addr = BASE + 32'd8;
      tick();
      tick();
      tick();
      chk("lat3_addr_ok_third_cycle", 64'(last_aok[1]), 64'd0);
      chk("lat1_addr_ok_third_cycle", 64'(last_aok[0]), 64'd1);
      req = 1'b0;
      for (int i = 0; i < 12; i++) tick();
`ifndef YSYX_22050710_SRAM_RAND_DELAY_EN
      chk("lat3_first_data_ok_cycle", 64'((ok_hist3.size() > 0) ? ok_hist3[0] - t0 : -1), 64'd3);
      chk("lat3_second_data_ok_cycle", 64'((ok_hist3.size() > 1) ? ok_hist3[1] - t0 : -1), 64'd4);
`endif

      // Reset with responses still in flight: none of them may ever complete.
      req = 1'b1; op = 1'b0; addr = BASE + 32'd8;
      tick();
      tick();
      req = 1'b0;
      rst = 1'b1;
      model_reset();
      pulses[0] = 0; pulses[1] = 0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset_inflight_pulses_dut%0d", k), 64'(pulses[k]), 64'd0);
         chk($sformatf("reset_inflight_addr_ok_dut%0d", k), 64'(last_aok[k]), 64'd1);
      end
      xfer(1'b0, BASE + 32'd8, 8'h00, 64'h0, 64'h1122_3344_BBBB_BBBB, "r_after_reset");

      for (int w = 0; w < 16; w++)
         xfer(1'b1, BASE + 32'(8 * w), 8'hFF, {$urandom, $urandom}, 64'h0, "preload");

      for (int i = 0; i < 400; i++) begin
         req = ($urandom_range(0, 3) != 0);
         op  = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 15))
            0:       addr = BASE - 32'd8;
            1:       addr = 32'h8000_2000;
            default: addr = BASE + 32'(8 * $urandom_range(0, 15));
         endcase
         addr  = addr | 32'($urandom_range(0, 7));
         wstrb = 8'($urandom);
         wdata = {$urandom, $urandom};
         size  = 2'($urandom);
         tick();
      end
      req = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      chk("drained_queue_dut1", 64'(last_aok[0]), 64'd1);
      chk("drained_queue_dut3", 64'(last_aok[1]), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22050710_sram_slave.md
YSYX_22050710_SRAM_SLAVE -- requirements
Module: ysyx_22050710_sram_slave

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WD, default 32, request address width.
REQ-002 SHALL have parameter SRAM_DATA_WD, default 64, data width.
REQ-003 SHALL have parameter SRAM_WMASK_WD, default 8, byte-strobe width.
REQ-004 SHALL have parameter MEM_DEPTH, default 1024, number of 64-bit words.
REQ-005 SHALL have parameter MEM_BASE, default 32'h8000_0000, byte address of word 0.
REQ-006 SHALL have parameter LATENCY, default 1, range 1..15, cycles from accept to data_ok.
REQ-007 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-009 SHALL have port i_req, input, 1, request valid.
REQ-010 SHALL have port i_op, input, 1, 1=write, 0=read.
REQ-011 SHALL have port i_size, input, 2, bytes code 0..3 = 1/2/4/8.
REQ-012 SHALL have port i_addr, input, SRAM_ADDR_WD, byte address.
REQ-013 SHALL have port i_wstrb, input, SRAM_WMASK_WD, write byte enables.
REQ-014 SHALL have port i_wdata, input, SRAM_DATA_WD, write data.
REQ-015 SHALL have port o_addr_ok, output, 1, request accepted this cycle when high with i_req.
REQ-016 SHALL have port o_data_ok, output, 1, one response completes this cycle.
REQ-017 SHALL have port o_rdata, output, SRAM_DATA_WD, read data, qualified by o_data_ok.

Function
REQ-018 Accept SHALL occur when i_req && o_addr_ok; o_addr_ok SHALL be high iff the response queue holds fewer than 2 entries, evaluated on occupancy before any same-cycle pop.
REQ-019 Word index SHALL be (i_addr - MEM_BASE) >> 3; the address is in range iff the index < MEM_DEPTH.
REQ-020 A read accept SHALL snapshot the full aligned 64-bit word into the queue entry; i_size and i_addr[2:0] SHALL be ignored for reads.
REQ-021 A write accept SHALL update memory bytes selected by i_wstrb at the accepting clock edge; i_size SHALL not be checked.
REQ-022 Out-of-range read SHALL return 0; out-of-range write SHALL be dropped; both SHALL still receive data_ok.
REQ-023 Each entry SHALL carry a countdown loaded with LATENCY at accept, decremented every cycle and saturating at 0, including while the entry is not at the head.
REQ-024 o_data_ok SHALL be a registered output, high for exactly one cycle per accepted request, in acceptance order, when the head countdown has reached 0; an accept at edge t SHALL give data_ok in cycle t+LATENCY with no stall.
REQ-025 o_rdata SHALL be the head snapshot for reads and 0 for writes and whenever o_data_ok is low.
REQ-026 The master SHALL always accept responses; the block SHALL not stall a response.
REQ-027 Accept and pop in the same cycle SHALL leave occupancy unchanged; with LATENCY=1, one request per cycle SHALL be sustained.

Reset
REQ-028 i_rst SHALL asynchronously clear the queue, counters and the LFSR to seed 4'hA, and drive o_data_ok=0, o_rdata=0 and o_addr_ok=1 after release.
REQ-029 In-flight requests at reset SHALL be discarded without response; memory contents SHALL not be reset.

Configuration
REQ-030 With YSYX_22050710_SRAM_RAND_DELAY_EN defined, each accept SHALL add 0..3 extra cycles to the loaded countdown, taken from a 4-bit LFSR (x^4+x^3+1) bits [1:0], stepped once per accept; in-order delivery SHALL be kept.
REQ-031 Without the macro, the latency SHALL be exactly LATENCY and no LFSR logic SHALL exist.

Structure
REQ-032 Package ysyx_22050710_sram_pkg SHALL hold the op encodings, size codes, queue entry typedef {op, rdata, countdown} and the LFSR seed.
REQ-033 The 2-entry in-order queue SHALL be sub-module ysyx_22050710_resp_queue; the memory array and accept logic SHALL stay in the top level.

Verification
REQ-034 Write 64'h1122334455667788 with wstrb 8'hFF to 0x80000008, then read it at LATENCY=1 -> read data_ok 1 cycle after accept, rdata=64'h1122334455667788.
REQ-035 Write wstrb 8'h0F with data 64'hAAAA_AAAA_BBBB_BBBB over that word -> a subsequent read returns 64'h11223344BBBBBBBB.
REQ-036 LATENCY=3, i_req held high with no responses yet -> 2 accepts, o_addr_ok low on the 3rd cycle, data_ok at t+3 and t+4 in order.
REQ-037 Read 0x7FFF_FFF8 and write MEM_BASE+8*MEM_DEPTH -> both get data_ok; read rdata=0; memory unchanged.
REQ-038 Assert i_rst with 2 entries pending -> o_data_ok never pulses for them, o_addr_ok=1 after release, and previously written data is still readable.
REQ-039 RAND_DELAY_EN, 100 random read requests -> every latency in LATENCY..LATENCY+3, responses in order, data matches a reference model.
